uart_tx_arbiter: RTL and testbench

//  Shares the single UART transmitter (uart_tx, drives Tx) between NUM_REQ on-chip message sources,
//  e.g. PUF response streamer, command echo and status reporter in uart_demo.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_tx_arbiter_if.sv | 30 +++
 rtl/uart_tx_arbiter_rr_pick.sv | 29 ++
 rtl/uart_tx_arbiter.sv | 132 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART TX definitions: byte width, arbiter FSM encoding, width helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

   localparam int BYTE_W = 8;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_SEND  = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_GAP   = 3'd4;

   typedef enum logic [2:0] {
      IDLE  = S_IDLE,
      LOAD  = S_LOAD,
      SEND  = S_SEND,
      DRAIN = S_DRAIN,
      GAP   = S_GAP
   } state_t;

   // Ceiling log2; callers pass value >= 2 so the result is at least 1.
   function automatic int clog2(input int value);
      int w;
      w = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) w = i + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Source-side and uart_tx-side signals of the TX arbiter.
// Latency: n/a (wiring only).
// Backpressure: ReqReady per source, TxBusy from uart_tx.
interface uart_tx_arbiter_if
   import uart_pkg::*;
#(
   parameter int NUM_REQ = 3
);
   logic [NUM_REQ-1:0]        Req;
   logic [BYTE_W*NUM_REQ-1:0] ReqData;
   logic [NUM_REQ-1:0]        ReqLast;
   logic [NUM_REQ-1:0]        ReqReady;
   logic [NUM_REQ-1:0]        Grant;
   logic [2:0]                GrantId;
   logic                      Active;
   logic                      Aborted;
   logic [BYTE_W-1:0]         TxData;
   logic                      TxStart;
   logic                      TxBusy;

   modport slave (
      input  Req, ReqData, ReqLast, TxBusy,
      output ReqReady, Grant, GrantId, Active, Aborted, TxData, TxStart
   );

   modport master (
      output Req, ReqData, ReqLast, TxBusy,
      input  ReqReady, Grant, GrantId, Active, Aborted, TxData, TxStart
   );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first set request at or above ptr, wrapping, as one-hot and index.
// Latency: combinational.
// Backpressure: none.
module rr_pick #(
   parameter int N = 3
) (
   input  logic [N-1:0] req,
   input  logic [2:0]   ptr,
   output logic [N-1:0] gnt,
   output logic [2:0]   idx,
   output logic         any
);
   int k;

   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      k   = 0;
      for (int i = 0; i < N; i++) begin
         k = (int'(ptr) + i) % N;
         if (!any && req[k]) begin
            any    = 1'b1;
            gnt[k] = 1'b1;
            idx    = 3'(k);
         end
      end
   end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter feeding one uart_tx from NUM_REQ byte sources.
// Latency: byte accepted at edge N -> TxStart high in cycle N+1.
// Backpressure: only the owner sees ReqReady, and only in LOAD while TxBusy is low.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ     = 3,
   parameter int GAP_CYCLES  = 16,
   parameter int STALL_LIMIT = 4096
) (
   input  logic             CLK_100MHz,
   input  logic             Reset_n,
   uart_tx_arbiter_if.slave bus
);
   localparam int STALL_W = clog2(STALL_LIMIT + 1);
   localparam int GAP_W   = clog2(GAP_CYCLES + 2);

   state_t              state;
   logic [2:0]          rr_ptr;
   logic [STALL_W-1:0]  stall_cnt;
   logic [GAP_W-1:0]    gap_cnt;
   logic                last_q;

   logic [NUM_REQ-1:0]  pick_gnt;
   logic [2:0]          pick_idx;
   logic                pick_any;
   logic [BYTE_W-1:0]   owner_data;
   logic                owner_last;
   logic                xfer;
   logic                stall_hit;
   logic                msg_done;
   logic [2:0]          next_ptr;

   rr_pick #(.N(NUM_REQ)) u_pick (
      .req (bus.Req),
      .ptr (rr_ptr),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .any (pick_any)
   );

   assign bus.ReqReady = (state == LOAD && !bus.TxBusy) ? bus.Grant : '0;
   assign xfer         = |(bus.Req & bus.ReqReady);
   assign owner_last   = |(bus.ReqLast & bus.Grant);
   assign stall_hit    = (stall_cnt >= STALL_W'(STALL_LIMIT - 1));
   assign next_ptr     = (bus.GrantId >= 3'(NUM_REQ - 1)) ? 3'd0 : bus.GrantId + 3'd1;

   // A message ends either on its last byte draining or on a stall timeout.
   assign msg_done = (state == LOAD && !xfer && stall_hit) ||
                     (state == DRAIN && !bus.TxBusy && last_q);

   always_comb begin
      owner_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (bus.Grant[i]) owner_data = bus.ReqData[BYTE_W*i +: BYTE_W];
      end
   end

   always_ff @(posedge CLK_100MHz or negedge Reset_n) begin
      if (!Reset_n) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         stall_cnt   <= '0;
         gap_cnt     <= '0;
         last_q      <= 1'b0;
         bus.Grant   <= '0;
         bus.GrantId <= '0;
         bus.Active  <= 1'b0;
         bus.Aborted <= 1'b0;
         bus.TxData  <= '0;
         bus.TxStart <= 1'b0;
      end else begin
         bus.TxStart <= 1'b0;
         bus.Aborted <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_any) begin
                  bus.Grant   <= pick_gnt;
                  bus.GrantId <= pick_idx;
                  bus.Active  <= 1'b1;
                  stall_cnt   <= '0;
                  state       <= LOAD;
               end
            end
            LOAD: begin
               if (xfer) begin
                  bus.TxData  <= owner_data;
                  bus.TxStart <= 1'b1;
                  last_q      <= owner_last;
                  stall_cnt   <= '0;
                  state       <= SEND;
               end else if (stall_hit) begin
                  bus.Aborted <= 1'b1;
                  stall_cnt   <= STALL_W'(STALL_LIMIT);
               end else begin
                  stall_cnt   <= stall_cnt + 1'b1;
               end
            end
            SEND: begin
               if (bus.TxBusy) state <= DRAIN;
            end
            DRAIN: begin
               if (!bus.TxBusy && !last_q) state <= LOAD;
            end
            GAP: begin
               if (gap_cnt >= GAP_W'(GAP_CYCLES - 1)) begin
                  bus.Grant  <= '0;
                  bus.Active <= 1'b0;
                  rr_ptr     <= next_ptr;
                  state      <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase

         // With no gap configured the owner is released straight from LOAD/DRAIN.
         if (msg_done) begin
            gap_cnt <= '0;
            if (GAP_CYCLES == 0) begin
               bus.Grant  <= '0;
               bus.Active <= 1'b0;
               rr_ptr     <= next_ptr;
               state      <= IDLE;
            end else begin
               state <= GAP;
            end
         end
      end
   end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: byte sources with stall control, uart_tx busy model,
// and a scoreboard of expected (source, byte) pairs checked at every TxStart.
module tb_uart_tx_arbiter;
   import uart_pkg::*;

   localparam int N     = 3;
   localparam int GAP_C = 4;
   localparam int STALL = 32;
   localparam int FRAME = 100;

   typedef struct packed {
      logic [15:0] stall;
      logic        last;
      logic [7:0]  data;
   } src_ent_t;

   typedef struct packed {
      logic [2:0] src;
      logic [7:0] data;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

   uart_tx_arbiter #(
      .NUM_REQ     (N),
      .GAP_CYCLES  (GAP_C),
      .STALL_LIMIT (STALL)
   ) dut (
      .CLK_100MHz (clk),
      .Reset_n    (rst_n),
      .bus        (bus)
   );

   src_ent_t srcq [N][$];
   exp_t     expq [$];
   int       wait_cnt [N];
   int       n_assert = 0;
   int       n_fail   = 0;
   int       abort_pulses = 0;
   logic     prev_abort = 1'b0;
   int       busy_cnt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // uart_tx model: busy from the cycle after TxStart, FRAME cycles long.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)                busy_cnt <= 0;
      else if (bus.TxStart)      busy_cnt <= FRAME;
      else if (busy_cnt > 0)     busy_cnt <= busy_cnt - 1;
   end
   assign bus.TxBusy = (busy_cnt != 0);

   // Sources: present head byte after waiting 'stall' ready cycles; drop the message on abort.
   always @(negedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (!rst_n || (bus.Aborted && bus.Grant[i])) begin
            srcq[i].delete();
            wait_cnt[i] = 0;
         end
         if (rst_n && srcq[i].size() > 0 && wait_cnt[i] >= int'(srcq[i][0].stall)) begin
            bus.Req[i]           = 1'b1;
            bus.ReqData[8*i +: 8] = srcq[i][0].data;
            bus.ReqLast[i]       = srcq[i][0].last;
            if (bus.ReqReady[i]) begin
               void'(srcq[i].pop_front());
               wait_cnt[i] = 0;
            end
         end else begin
            bus.Req[i]           = 1'b0;
            bus.ReqData[8*i +: 8] = 8'h00;
            bus.ReqLast[i]       = 1'b0;
            if (rst_n && srcq[i].size() > 0 && bus.ReqReady[i]) wait_cnt[i]++;
         end
      end
   end

   // Output monitor and scoreboard.
   always @(negedge clk) begin
      if (!rst_n) begin
         expq.delete();
         prev_abort = 1'b0;
      end else begin
         if (bus.TxStart) begin
            if (expq.size() == 0) begin
               check("tx_unexpected", 32'(expq.size()), 32'd1);
            end else begin
               exp_t e;
               e = expq.pop_front();
               check("tx_data",  32'(bus.TxData),  32'(e.data));
               check("tx_owner", 32'(bus.GrantId), 32'(e.src));
               check("tx_grant", 32'(bus.Grant),   32'(1 << e.src));
            end
         end
         check("grant_onehot0", 32'($onehot0(bus.Grant)), 32'd1);
         check("rdy_nonowner", 32'(bus.ReqReady & ~bus.Grant), 32'd0);
         if (bus.TxBusy) check("rdy_while_busy", 32'(bus.ReqReady), 32'd0);
         if (bus.Aborted) begin
            abort_pulses++;
            check("abort_width", 32'(prev_abort), 32'd0);
         end
         prev_abort = bus.Aborted;
      end
   end

   task automatic add_byte(input int src, input logic [7:0] data, input logic last,
                           input int stall, input bit expect_out);
      src_ent_t s;
      exp_t     e;
      s.stall = 16'(stall);
      s.last  = last;
      s.data  = data;
      srcq[src].push_back(s);
      if (expect_out) begin
         e.src  = 3'(src);
         e.data = data;
         expq.push_back(e);
      end
   endtask

   task automatic push_exp(input int src, input logic [7:0] data);
      exp_t e;
      e.src  = 3'(src);
      e.data = data;
      expq.push_back(e);
   endtask

   function automatic bit all_quiet();
      bit q;
      q = (expq.size() == 0) && !bus.Active;
      for (int i = 0; i < N; i++) if (srcq[i].size() != 0) q = 1'b0;
      return q;
   endfunction

   task automatic wait_idle(input string tag, input int budget);
      int t;
      t = 0;
      @(negedge clk);
      while (!all_quiet() && t < budget) begin
         @(negedge clk);
         t++;
      end
      check(tag, 32'(t >= budget), 32'd0);
   endtask

   task automatic wait_exp_left(input string tag, input int left, input int budget);
      int t;
      t = 0;
      while (expq.size() > left && t < budget) begin
         @(negedge clk);
         t++;
      end
      check(tag, 32'(t >= budget), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rdy"},     32'(bus.ReqReady), 32'd0);
      check({tag, "_grant"},   32'(bus.Grant),    32'd0);
      check({tag, "_grantid"}, 32'(bus.GrantId),  32'd0);
      check({tag, "_active"},  32'(bus.Active),   32'd0);
      check({tag, "_aborted"}, 32'(bus.Aborted),  32'd0);
      check({tag, "_txstart"}, 32'(bus.TxStart),  32'd0);
      check({tag, "_txdata"},  32'(bus.TxData),   32'd0);
   endtask

   initial begin
      int t;
      int gap_len;

      // Reset values
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;

      // Single source, 3-byte message, then the idle gap
      add_byte(0, 8'hA5, 1'b0, 0, 1'b1);
      add_byte(0, 8'h5A, 1'b0, 0, 1'b1);
      add_byte(0, 8'hFF, 1'b1, 0, 1'b1);
      wait_exp_left("t1_bytes", 0, 2000);
      t = 0;
      while (!bus.TxBusy && t < 50)   begin @(negedge clk); t++; end
      while (bus.TxBusy && t < 400)   begin @(negedge clk); t++; end
      gap_len = 0;
      while (bus.Active && t < 500)   begin gap_len++; @(negedge clk); t++; end
      check("t1_timeout", 32'(t >= 500), 32'd0);
      check("t1_gap_len", 32'(gap_len), 32'(GAP_C + 1));
      check("t1_grant_released", 32'(bus.Grant), 32'd0);

      // All three request from reset: served 0,1,2 without interleaving
      do_reset();
      add_byte(0, 8'h10, 1'b0, 0, 1'b1);
      add_byte(0, 8'h11, 1'b1, 0, 1'b1);
      add_byte(1, 8'h20, 1'b0, 0, 1'b1);
      add_byte(1, 8'h21, 1'b1, 0, 1'b1);
      add_byte(2, 8'h30, 1'b0, 0, 1'b1);
      add_byte(2, 8'h31, 1'b1, 0, 1'b1);
      wait_idle("t2_done", 3000);

      // Src1 streams two messages; src2 arrives mid-message and goes next
      add_byte(1, 8'h40, 1'b0, 0, 1'b1);
      add_byte(1, 8'h41, 1'b0, 0, 1'b1);
      add_byte(1, 8'h42, 1'b1, 0, 1'b1);
      add_byte(1, 8'h43, 1'b0, 0, 1'b0);
      add_byte(1, 8'h44, 1'b0, 0, 1'b0);
      add_byte(1, 8'h45, 1'b1, 0, 1'b0);
      wait_exp_left("t3_first", 2, 500);
      add_byte(2, 8'h50, 1'b0, 0, 1'b1);
      add_byte(2, 8'h51, 1'b1, 0, 1'b1);
      push_exp(1, 8'h43);
      push_exp(1, 8'h44);
      push_exp(1, 8'h45);
      wait_idle("t3_done", 5000);

      // Owner withholds its 2nd byte for STALL cycles: abort, src1 served next
      do_reset();
      abort_pulses = 0;
      add_byte(0, 8'h60, 1'b0, 0,     1'b1);
      add_byte(0, 8'h61, 1'b1, STALL, 1'b0);
      add_byte(1, 8'h70, 1'b1, 0,     1'b1);
      wait_idle("t4_done", 3000);
      check("t4_abort_count", 32'(abort_pulses), 32'd1);

      // STALL-1 cycles of withholding: no abort, byte goes out
      abort_pulses = 0;
      add_byte(0, 8'h80, 1'b0, 0,         1'b1);
      add_byte(0, 8'h81, 1'b1, STALL - 1, 1'b1);
      wait_idle("t5_done", 3000);
      check("t5_abort_count", 32'(abort_pulses), 32'd0);

      // Reset asserted during DRAIN: outputs clear without a clock edge, pointer back to 0
      add_byte(1, 8'h90, 1'b0, 0, 1'b1);
      add_byte(1, 8'h91, 1'b1, 0, 1'b1);
      wait_exp_left("t6_first", 1, 500);
      t = 0;
      while (!bus.TxBusy && t < 50) begin @(negedge clk); t++; end
      check("t6_busy_seen", 32'(t >= 50), 32'd0);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("t6_async");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      add_byte(1, 8'hA1, 1'b1, 0, 1'b0);
      add_byte(0, 8'hB0, 1'b1, 0, 1'b0);
      push_exp(0, 8'hB0);
      push_exp(1, 8'hA1);
      wait_idle("t6_done", 2000);

      repeat (5) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
